alu_exec_stage: RTL

- Execute-stage consumer of the control decoder's {reg_write, aluop} bundle for the MIPS core; it is the receiving end of that interface.
- Accepts one decoded R-type instruction plus two register operands per handshake, computes the ALU result, and presents a registered writeback bundle to the register-file write port.
- Sits between decode/regfile-read and writeback.
- A 2-entry skid buffer decouples ready paths, so neither side sees a combinational ready path.

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/alu_core.sv | 44 ++++
 rtl/alu_exec_stage.sv | 122 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared MIPS core definitions: ALU op encodings, R-type funct codes and the
// writeback bundle carried from execute to the register-file write port.
package cpu_pkg;

    localparam int CPU_DW = 32;
    localparam int CPU_RW = 5;

    localparam logic [4:0] ADD_OP  = 5'b00000;
    localparam logic [4:0] ADDU_OP = 5'b00001;
    localparam logic [4:0] SUBU_OP = 5'b00010;
    localparam logic [4:0] AND_OP  = 5'b00011;
    localparam logic [4:0] OR_OP   = 5'b00100;
    localparam logic [4:0] SLT_OP  = 5'b00101;

    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_SLT  = 6'h2a;

    typedef struct packed {
        logic              wr_en;
        logic [CPU_RW-1:0] rd;
        logic [CPU_DW-1:0] result;
        logic              illegal;
        logic              ovf;
    } wb_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU for the execute stage: (a, b, aluop) -> (result, illegal, ovf).
// ovf is raised only for ADD; unrecognised ops give result 0 with illegal set.
module alu_core
    import cpu_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [4:0]    aluop,
    output logic [DW-1:0] result,
    output logic          illegal,
    output logic          ovf
);

    logic [DW-1:0] sum;
    logic [DW-1:0] diff;
    logic          lt_signed;

    always_comb begin
        sum       = a + b;
        diff      = a - b;
        lt_signed = $signed(a) < $signed(b);

        result  = '0;
        illegal = 1'b0;
        ovf     = 1'b0;

        case (aluop)
            ADD_OP: begin
                result = sum;
                // Like-signed operands producing an opposite-signed sum.
                ovf    = (a[DW-1] == b[DW-1]) && (sum[DW-1] != a[DW-1]);
            end
            ADDU_OP: result = sum;
            SUBU_OP: result = diff;
            AND_OP:  result = a & b;
            OR_OP:   result = a | b;
            SLT_OP:  result[0] = lt_signed;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: ALU plus a 2-entry (main + skid) buffer between decode and writeback.
// Define ALU_OVF_TRAP_EN to suppress the register write on ADD overflow.
module alu_exec_stage
    import cpu_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_reg_write,
    input  logic [4:0]    in_aluop,
    input  logic [RW-1:0] in_rd,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_wr_en,
    output logic [RW-1:0] out_rd,
    output logic [DW-1:0] out_result,
    output logic          out_illegal,
    output logic          out_ovf
);

    typedef struct packed {
        logic          wr_en;
        logic [RW-1:0] rd;
        logic [DW-1:0] result;
        logic          illegal;
        logic          ovf;
    } entry_t;

    entry_t        main_q, main_d;
    entry_t        skid_q, skid_d;
    entry_t        new_entry;
    logic          main_valid_q, main_valid_d;
    logic          skid_valid_q, skid_valid_d;

    logic [DW-1:0] alu_result;
    logic          alu_illegal;
    logic          alu_ovf;
    logic          trap;
    logic          accept;
    logic          drain;

    alu_core #(.DW(DW)) u_alu_core (
        .a       (in_a),
        .b       (in_b),
        .aluop   (in_aluop),
        .result  (alu_result),
        .illegal (alu_illegal),
        .ovf     (alu_ovf)
    );

    always_comb begin
`ifdef ALU_OVF_TRAP_EN
        trap = alu_ovf;
`else
        trap = 1'b0;
`endif
        new_entry.wr_en   = in_reg_write & ~alu_illegal & ~trap;
        new_entry.rd      = in_rd;
        new_entry.result  = alu_result;
        new_entry.illegal = alu_illegal;
        new_entry.ovf     = alu_ovf;
    end

    // in_ready comes straight from a flop so upstream never sees out_ready combinationally.
    assign in_ready = ~skid_valid_q;
    assign accept   = in_valid & in_ready;
    assign drain    = main_valid_q & out_ready;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;

        if (!main_valid_q) begin
            if (accept) begin
                main_d       = new_entry;
                main_valid_d = 1'b1;
            end
        end else if (drain) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d = new_entry;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = new_entry;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid   = main_valid_q;
    assign out_wr_en   = main_valid_q & main_q.wr_en;
    assign out_rd      = main_q.rd;
    assign out_result  = main_q.result;
    assign out_illegal = main_q.illegal;
    assign out_ovf     = main_q.ovf;

endmodule
